// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : CPU front end. Owns the PC, fetches instruction words over a
//            req/ack handshake, holds each word for the execute stage and
//            computes the next PC from the jump/branch/zero outcome.
// Options  : ILLEGAL_OPCODE_TRAP_EN - halt on an illegal opcode instead of
//            skipping the word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int          INSTR_W  = 24,
  parameter int          ADDR_W   = 16,
  parameter int          IMM_W    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [5:0]         opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic               illegal_op,
  output logic [ADDR_W-1:0]  pc
);

  localparam logic [ADDR_W-1:0] c_resetPc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_one     = ADDR_W'(1);
  localparam int                c_jumpW   = INSTR_W - 6;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t r_state;

  logic [5:0]        w_rdataOp;
  logic [ADDR_W-1:0] w_pcInc;
  logic [ADDR_W-1:0] w_branchOff;
  logic [ADDR_W-1:0] w_jumpTarget;
  logic [ADDR_W-1:0] w_nextPc;

  // Decoder's set of implemented opcodes; anything else is illegal.
  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011,
      6'b000100, 6'b001000, 6'b000010: isLegalOp = 1'b1;
      default:                         isLegalOp = 1'b0;
    endcase
  endfunction

  assign w_rdataOp   = imem_rdata[INSTR_W-1:INSTR_W-6];
  assign w_pcInc     = pc + c_one;
  assign w_branchOff = {{(ADDR_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  // Jump field is everything below the opcode, fitted to the PC width.
  generate
    if (c_jumpW >= ADDR_W) begin : g_jumpTrunc
      assign w_jumpTarget = instr[ADDR_W-1:0];
    end else begin : g_jumpZext
      assign w_jumpTarget = {{(ADDR_W-c_jumpW){1'b0}}, instr[c_jumpW-1:0]};
    end
  endgenerate

  // Next-PC selection: jump beats a taken branch, otherwise sequential.
  always_comb begin
    w_nextPc = w_pcInc;
    if (jump) begin
      w_nextPc = w_jumpTarget;
    end else if (branch && zero) begin
      w_nextPc = w_pcInc + w_branchOff;
    end
  end

  // Fetch/execute/halt sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      pc          <= c_resetPc;
      imem_req    <= 1'b0;
      imem_addr   <= c_resetPc;
      instr       <= '0;
      opcode      <= '0;
      instr_valid <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_op  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!imem_req) begin
            // Idle after reset or a skipped word: start a request at pc.
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            if (isLegalOp(w_rdataOp)) begin
              instr       <= imem_rdata;
              opcode      <= w_rdataOp;
              instr_valid <= 1'b1;
              r_state     <= S_EXEC;
            end else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
              instr      <= imem_rdata;
              opcode     <= w_rdataOp;
              illegal_op <= 1'b1;
              r_state    <= S_HALT;
`else
              // Skip the word; the idle branch re-requests at the new pc.
              pc <= w_pcInc;
`endif
            end
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            // Chain straight into the next request to keep 2 cycles/instr.
            instr_valid <= 1'b0;
            pc          <= w_nextPc;
            imem_addr   <= w_nextPc;
            imem_req    <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

`ifndef ILLEGAL_OPCODE_TRAP_EN
  assign illegal_op = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 24-bit CPU: owns the PC, fetches instruction words from instruction memory over a req/ack handshake, and presents the opcode and full instruction word to the control-unit decoder.
- Holds each instruction until the execute stage signals completion.
- Then takes the resolved branch, zero and jump outcome and computes the next PC.
- It is the producer side of the opcode interface the decoder consumes.

Parameters:
- INSTR_W, 24, instruction word width; opcode = instr[INSTR_W-1:INSTR_W-6].
- ADDR_W, 16, PC/instruction address width (word addressed).
- IMM_W, 8, branch offset field width = instr[IMM_W-1:0], two's complement.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction word.
- opcode  out  6  opcode field of the held instruction, to the decoder.
- instr  out  INSTR_W  held instruction word.
- instr_valid  out  1  opcode/instr valid for execute.
- exec_done  in  1  execute finished the held instruction.
- branch  in  1  decoder Branch.
- zero  in  1  ALU zero flag.
- jump  in  1  decoder Jump.
- illegal_op  out  1  trap flag (see Optional Feature).
- pc  out  ADDR_W  current PC.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, opcode=0, instr_valid=0, illegal_op=0.
  - State goes to FETCH.
  - Reset mid-fetch or mid-execute abandons the transaction with no further outputs.
- States: FETCH, EXEC, HALT. All outputs are registered.
- FETCH:
  - imem_req=1, imem_addr=pc; both stay stable until imem_ack is sampled high.
  - An ack in the first cycle req is high is legal.
  - On ack: capture imem_rdata into instr and opcode, drop imem_req, go to EXEC.
  - imem_rdata is ignored when ack=0.
  - imem_ack is ignored outside FETCH.
- EXEC:
  - instr_valid=1; instr and opcode are held stable.
  - branch, zero and jump are sampled only in the cycle exec_done=1. exec_done in the first EXEC cycle is legal.
  - Next PC, evaluated in priority order:
    - jump=1: instr[INSTR_W-7:0] truncated or zero-extended to ADDR_W. Jump wins even if branch&zero.
    - branch&zero: pc+1+sext(instr[IMM_W-1:0]).
    - otherwise: pc+1.
  - All PC arithmetic is modulo 2^ADDR_W (wraps).
  - On exec_done: instr_valid drops, pc updates, go to FETCH. The next request carries the new pc.
- Throughput: minimum 2 cycles per instruction (ack and exec_done both immediate).
- Legal opcodes: 000000, 100011, 101011, 000100, 001000, 000010 (jump).
- HALT: terminal; exited only by reset.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - An acked word with an opcode outside the legal set goes to HALT instead of EXEC.
  - In HALT: illegal_op=1 (sticky), instr and opcode hold the faulting word, pc holds the faulting address, imem_req=0, instr_valid=0.
- Undefined:
  - An illegal word is skipped: pc becomes pc+1, state returns to FETCH the next cycle.
  - instr_valid is never asserted for that word.
  - illegal_op is tied 0.

Test Plan:
- Reset: hold rst_n=0, release -> first cycle imem_req=1, imem_addr=0x0000, instr_valid=0.
- Back-to-back: R-type 0x000123 at 0, ack immediate, exec_done immediate -> instr_valid one cycle with opcode=000000; next imem_addr=0x0001 two cycles after the first req.
- Delayed ack: ack after 3 cycles with garbage rdata before ack -> req and addr stable for 4 cycles; only the word present with ack is captured.
- BEQ at pc=5, imm=0xFD:
  - branch=1, zero=1 -> next fetch 0x0003.
  - zero=0 -> next fetch 0x0006.
  - exec_done held low 5 cycles -> instr_valid stays high and instr stays stable throughout.
- Jump and wrap:
  - jump=1 and branch=zero=1, jump field 0x0040 -> next fetch 0x0040.
  - pc=0xFFFF sequential -> next fetch 0x0000.
  - rst_n pulsed during EXEC -> restart fetch at 0x0000.
- Illegal opcode 111111 at pc=7:
  - With ILLEGAL_OPCODE_TRAP_EN -> illegal_op=1, pc=7, no further imem_req.
  - Without -> next imem_addr=0x0008, instr_valid never high.
